// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if - bundle between decode, hazard control, execute and memory.
//
// Signals:
//   stall, flush           hazard-control hold / bubble request
//   id_i_*                 decode bundle (alu_op, alu_sel, reg0, reg1, waddr, wreg)
//   ex_o_wreg/waddr/wdata  combinational forwarding triple back to decode
//   ex_o_busy              stall request from the serial shifter
//   mem_i_wreg/waddr/wdata EX/MEM registered result for the memory stage
//
// Modports:
//   master - drives decode bundle and hazard control, observes results
//   slave  - the execute stage itself
// -----------------------------------------------------------------------------
interface ex_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          stall;
  logic          flush;
  logic [7:0]    id_i_alu_op;
  logic [2:0]    id_i_alu_sel;
  logic [DW-1:0] id_i_reg0;
  logic [DW-1:0] id_i_reg1;
  logic [AW-1:0] id_i_waddr;
  logic          id_i_wreg;
  logic          ex_o_wreg;
  logic [AW-1:0] ex_o_waddr;
  logic [DW-1:0] ex_o_wdata;
  logic          ex_o_busy;
  logic          mem_i_wreg;
  logic [AW-1:0] mem_i_waddr;
  logic [DW-1:0] mem_i_wdata;

  modport master (
    output stall, flush, id_i_alu_op, id_i_alu_sel, id_i_reg0, id_i_reg1,
           id_i_waddr, id_i_wreg,
    input  ex_o_wreg, ex_o_waddr, ex_o_wdata, ex_o_busy,
           mem_i_wreg, mem_i_waddr, mem_i_wdata
  );

  modport slave (
    input  stall, flush, id_i_alu_op, id_i_alu_sel, id_i_reg0, id_i_reg1,
           id_i_waddr, id_i_wreg,
    output ex_o_wreg, ex_o_waddr, ex_o_wdata, ex_o_busy,
           mem_i_wreg, mem_i_waddr, mem_i_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage - openMIPS execute stage (ID/EX register, logic/shift ALU,
//            forwarding triple, EX/MEM register).
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - ex_stage_if.slave: decode bundle in, stall/flush in,
//          forwarding triple + busy out, EX/MEM register out
//
// Configuration:
//   EX_SERIAL_SHIFT_EN - when defined, shifts run on a 1-bit-per-cycle
//   serial shifter that raises ex_o_busy; otherwise a single-cycle barrel
//   shifter is used and ex_o_busy is tied low.
// -----------------------------------------------------------------------------
module ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  // ID/EX register
  logic [7:0]    r_op;
  logic [2:0]    r_sel;
  logic [DW-1:0] r_reg0;
  logic [DW-1:0] r_reg1;
  logic [AW-1:0] r_waddr;
  logic          r_wreg;

  // EX/MEM register
  logic          r_mem_wreg;
  logic [AW-1:0] r_mem_waddr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_busy;
  logic [4:0]    w_shamt;
  logic [DW-1:0] w_logic_res;
  logic [DW-1:0] w_shift_res;
  logic [DW-1:0] w_result;

  // NOTE: state is written with non-blocking assignments under an async
  // reset so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_sel   <= '0;
      r_reg0  <= '0;
      r_reg1  <= '0;
      r_waddr <= '0;
      r_wreg  <= 1'b0;
    end else if (bus.flush) begin
      r_op    <= '0;
      r_sel   <= '0;
      r_reg0  <= '0;
      r_reg1  <= '0;
      r_waddr <= '0;
      r_wreg  <= 1'b0;
    end else if (!(bus.stall || w_busy)) begin
      r_op    <= bus.id_i_alu_op;
      r_sel   <= bus.id_i_alu_sel;
      r_reg0  <= bus.id_i_reg0;
      r_reg1  <= bus.id_i_reg1;
      r_waddr <= bus.id_i_waddr;
      r_wreg  <= bus.id_i_wreg;
    end
  end

  // Only the low five bits of reg0 form the shift amount.
  assign w_shamt = r_reg0[4:0];

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_logic_res = '0;
    case (r_op)
      OP_AND:  w_logic_res = r_reg0 & r_reg1;
      OP_OR:   w_logic_res = r_reg0 | r_reg1;
      OP_XOR:  w_logic_res = r_reg0 ^ r_reg1;
      OP_NOR:  w_logic_res = ~(r_reg0 | r_reg1);
      default: w_logic_res = '0;
    endcase
  end

`ifdef EX_SERIAL_SHIFT_EN
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_acc;
  logic [4:0]    r_cnt;
  logic          w_shift_op_ok;
  logic          w_start;

  function automatic logic [DW-1:0] shift1(input logic [7:0] op,
                                           input logic [DW-1:0] v);
    case (op)
      OP_SLL:  return v << 1;
      OP_SRL:  return v >> 1;
      OP_SRA:  return {v[DW-1], v[DW-1:1]};
      default: return '0;
    endcase
  endfunction

  assign w_shift_op_ok = (r_op == OP_SLL) || (r_op == OP_SRL) || (r_op == OP_SRA);
  assign w_start = (r_state == ST_IDLE) && (r_sel == SEL_SHIFT) &&
                   w_shift_op_ok && (w_shamt != 5'd0);
  // The start cycle already performs the first 1-bit step, so busy covers
  // shamt cycles and the result appears in DONE: shamt+1 cycles in total.
  assign w_busy = w_start || (r_state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_acc   <= shift1(r_op, r_reg1);
          r_cnt   <= w_shamt - 5'd1;
          r_state <= (w_shamt == 5'd1) ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          r_acc <= shift1(r_op, r_acc);
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_state <= ST_DONE;
        end
        // ID/EX still holds the shift op in DONE; leaving only when the
        // pipeline advances keeps a stall here from restarting the shift.
        ST_DONE: if (!bus.stall) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_res = '0;
    if (r_state == ST_DONE)                    w_shift_res = r_acc;
    else if (w_shift_op_ok && w_shamt == 5'd0) w_shift_res = r_reg1;
  end
`else
  assign w_busy = 1'b0;

  always_comb begin
    w_shift_res = '0;
    case (r_op)
      OP_SLL:  w_shift_res = r_reg1 << w_shamt;
      OP_SRL:  w_shift_res = r_reg1 >> w_shamt;
      OP_SRA:  w_shift_res = $signed(r_reg1) >>> w_shamt;
      default: w_shift_res = '0;
    endcase
  end
`endif

  always_comb begin
    w_result = '0;
    case (r_sel)
      SEL_LOGIC: w_result = w_logic_res;
      SEL_SHIFT: w_result = w_shift_res;
      default:   w_result = '0;
    endcase
  end

  assign bus.ex_o_wreg  = r_wreg & ~w_busy;
  assign bus.ex_o_waddr = r_waddr;
  assign bus.ex_o_wdata = w_result;
  assign bus.ex_o_busy  = w_busy;

  // EX/MEM: a busy shifter sends bubbles downstream; stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wreg  <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else if (!bus.stall) begin
      if (w_busy) begin
        r_mem_wreg  <= 1'b0;
        r_mem_waddr <= '0;
        r_mem_wdata <= '0;
      end else begin
        r_mem_wreg  <= bus.ex_o_wreg;
        r_mem_waddr <= bus.ex_o_waddr;
        r_mem_wdata <= bus.ex_o_wdata;
      end
    end
  end

  assign bus.mem_i_wreg  = r_mem_wreg;
  assign bus.mem_i_waddr = r_mem_waddr;
  assign bus.mem_i_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage - directed testbench for ex_stage. Expected results are pushed
// to forwarding and EX/MEM queues as instructions are driven and popped when
// the corresponding stage output is sampled (#1 after the rising edge).
// -----------------------------------------------------------------------------
module tb_ex_stage;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  ex_stage_if #(.DW(32), .AW(5)) bus ();

  ex_stage #(.DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  res_t fwd_q[$];
  res_t mem_q[$];
  res_t last_fwd;
  res_t last_mem;
  int   errors = 0;
  int   checks = 0;

  function automatic res_t mk(input logic we, input logic [4:0] wa,
                              input logic [31:0] wd);
    res_t r;
    r.wreg  = we;
    r.waddr = wa;
    r.wdata = wd;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fwd_is(input string tag, input res_t e);
    check({tag, ".ex_wreg"},  32'(bus.ex_o_wreg),  32'(e.wreg));
    check({tag, ".ex_waddr"}, 32'(bus.ex_o_waddr), 32'(e.waddr));
    check({tag, ".ex_wdata"}, bus.ex_o_wdata,      e.wdata);
  endtask

  task automatic check_mem_is(input string tag, input res_t e);
    check({tag, ".mem_wreg"},  32'(bus.mem_i_wreg),  32'(e.wreg));
    check({tag, ".mem_waddr"}, 32'(bus.mem_i_waddr), 32'(e.waddr));
    check({tag, ".mem_wdata"}, bus.mem_i_wdata,      e.wdata);
  endtask

  task automatic check_fwd(input string tag);
    check({tag, ".fwd_q_nonempty"}, 32'(fwd_q.size() != 0), 32'd1);
    if (fwd_q.size() != 0) begin
      last_fwd = fwd_q.pop_front();
      check_fwd_is(tag, last_fwd);
    end
  endtask

  task automatic check_mem(input string tag);
    check({tag, ".mem_q_nonempty"}, 32'(mem_q.size() != 0), 32'd1);
    if (mem_q.size() != 0) begin
      last_mem = mem_q.pop_front();
      check_mem_is(tag, last_mem);
    end
  endtask

  task automatic push(input res_t e);
    fwd_q.push_back(e);
    mem_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input logic [4:0] wa, input logic we);
    bus.id_i_alu_op  = op;
    bus.id_i_alu_sel = sel;
    bus.id_i_reg0    = r0;
    bus.id_i_reg1    = r1;
    bus.id_i_waddr   = wa;
    bus.id_i_wreg    = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);

    // Reset state, sampled before any clock edge.
    #2;
    check_fwd_is("reset", '0);
    check_mem_is("reset", '0);
    check("reset.busy", 32'(bus.ex_o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // OR
    drive(8'h25, 3'd1, 32'h0000_FF00, 32'h0F0F_0000, 5'd5, 1'b1);
    push(mk(1'b1, 5'd5, 32'h0F0F_FF00));
    step();
    check_fwd("or");

`ifndef EX_SERIAL_SHIFT_EN
    // SRA, back-to-back with OR
    drive(8'h03, 3'd2, 32'h0000_0004, 32'h8000_0010, 5'd7, 1'b1);
    push(mk(1'b1, 5'd7, 32'hF800_0001));
    step();
    check_mem("or");
    check_fwd("sra");

    // SRA with upper shift-amount bits set: only r0[4:0]=4 counts
    drive(8'h03, 3'd2, 32'h0000_0024, 32'h8000_0010, 5'd8, 1'b1);
    push(mk(1'b1, 5'd8, 32'hF800_0001));
    step();
    check_mem("sra");
    check_fwd("sra_upper");

    // SRL zero-fills
    drive(8'h02, 3'd2, 32'hFFFF_FFE8, 32'h8000_0000, 5'd10, 1'b1);
    push(mk(1'b1, 5'd10, 32'h0080_0000));
    step();
    check_mem("sra_upper");
    check_fwd("srl");

    // SLL by the maximum amount
    drive(8'h7C, 3'd2, 32'h0000_001F, 32'h0000_0003, 5'd11, 1'b1);
    push(mk(1'b1, 5'd11, 32'h8000_0000));
    step();
    check_mem("srl");
    check_fwd("sll31");
`else
    // Serial SLL by 3: busy for 3 cycles, result in the 4th
    drive(8'h7C, 3'd2, 32'h0000_0003, 32'h0000_0001, 5'd3, 1'b1);
    step();
    check_mem("or");
    check("ser0.busy", 32'(bus.ex_o_busy), 32'd1);
    check("ser0.ex_wreg", 32'(bus.ex_o_wreg), 32'd0);
    // Following instruction must wait in decode during the shift
    drive(8'h24, 3'd1, 32'hFFFF_0000, 32'h1234_5678, 5'd4, 1'b1);
    step();
    check("ser1.busy", 32'(bus.ex_o_busy), 32'd1);
    check("ser1.mem_wreg", 32'(bus.mem_i_wreg), 32'd0);
    step();
    check("ser2.busy", 32'(bus.ex_o_busy), 32'd1);
    check("ser2.mem_wreg", 32'(bus.mem_i_wreg), 32'd0);
    step();
    check("ser3.busy", 32'(bus.ex_o_busy), 32'd0);
    check_fwd_is("ser_done", mk(1'b1, 5'd3, 32'h0000_0008));
    check("ser3.mem_wreg", 32'(bus.mem_i_wreg), 32'd0);
    mem_q.push_back(mk(1'b1, 5'd3, 32'h0000_0008));
    push(mk(1'b1, 5'd4, 32'h1234_0000));
    step();
    check_mem("sll_serial");
    check_fwd("held_instr");
`endif

    // NOR of zeros, captured with no bubble after the previous instruction
    drive(8'h27, 3'd1, 32'h0, 32'h0, 5'd9, 1'b1);
    push(mk(1'b1, 5'd9, 32'hFFFF_FFFF));
    step();
    check_mem("pre_nor");
    check_fwd("nor");

    // AND to register 0 passes through unmodified
    drive(8'h24, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b1);
    push(mk(1'b1, 5'd0, 32'hF000_F000));
    step();
    check_mem("nor");
    check_fwd("and_r0");

    // XOR
    drive(8'h26, 3'd1, 32'hAAAA_5555, 32'hFFFF_0000, 5'd31, 1'b1);
    push(mk(1'b1, 5'd31, 32'h5555_5555));
    step();
    check_mem("and_r0");
    check_fwd("xor");

    // Shift opcode under the LOGIC group is unknown there: result 0
    drive(8'h7C, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
    push(mk(1'b1, 5'd6, 32'h0));
    step();
    check_mem("xor");
    check_fwd("bad_op");

    // NOP select with a valid opcode: result 0
    drive(8'h25, 3'd0, 32'h0000_FFFF, 32'hFFFF_0000, 5'd12, 1'b1);
    push(mk(1'b1, 5'd12, 32'h0));
    step();
    check_mem("bad_op");
    check_fwd("nop_sel");

    // Stall for 3 cycles: both pipeline registers hold
    drive(8'h25, 3'd1, 32'h0000_0001, 32'h0000_0002, 5'd13, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_mem_is("stall", last_mem);
      check_fwd_is("stall", last_fwd);
    end
    bus.stall = 1'b0;
    push(mk(1'b1, 5'd13, 32'h0000_0003));
    step();
    check_mem("after_stall");
    check_fwd("after_stall");

    // Flush and stall together: ID/EX takes the bubble, EX/MEM holds
    drive(8'h26, 3'd1, 32'h0000_000F, 32'h0000_0001, 5'd14, 1'b1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    check_fwd_is("flush_stall", '0);
    check_mem_is("flush_stall", last_mem);
    void'(mem_q.pop_front());  // flushed instruction never reaches EX/MEM
    mem_q.push_back('0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    push(mk(1'b1, 5'd14, 32'h0000_000E));
    step();
    check_mem("bubble");
    check_fwd("after_flush_stall");

    // Flush alone: bubble in ID/EX, then bubble in EX/MEM one cycle later
    drive(8'h25, 3'd1, 32'h0000_0001, 32'h0000_0001, 5'd15, 1'b1);
    bus.flush = 1'b1;
    push('0);
    step();
    check_mem("after_flush_stall");
    check_fwd("flush");
    bus.flush = 1'b0;
    drive(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    push('0);
    step();
    check_mem("flush");
    check_fwd("nop");

    // Load both stages with live data, then assert reset between edges
    drive(8'h25, 3'd1, 32'h0000_00F0, 32'h0000_000F, 5'd17, 1'b1);
    push(mk(1'b1, 5'd17, 32'h0000_00FF));
    step();
    check_mem("nop");
    check_fwd("pre_reset0");
    drive(8'h24, 3'd1, 32'hFFFF_FFFF, 32'h00FF_00FF, 5'd18, 1'b1);
    push(mk(1'b1, 5'd18, 32'h00FF_00FF));
    step();
    check_mem("pre_reset0");
    check_fwd("pre_reset1");
    #2;
    rst = 1'b1;
    #1;
    check_fwd_is("async_rst", '0);
    check_mem_is("async_rst", '0);
    check("async_rst.busy", 32'(bus.ex_o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
